sevseg_scan_ctrl: RTL



---
 rtl/sevseg_pkg.sv | 24 ++
 rtl/sevseg_slot_timer.sv | 37 +++
 rtl/sevseg_scan_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sevseg_pkg.sv
// Shared types and constants for the two-digit seven-segment scanner.
// State encoding, blank patterns and a counter-width helper.
package sevseg_pkg;

  typedef enum logic [1:0] {
    BLANK_LO = 2'd0,
    SHOW_LO  = 2'd1,
    BLANK_HI = 2'd2,
    SHOW_HI  = 2'd3
  } sevseg_state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [1:0] DIG_OFF = 2'b11;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sevseg_slot_timer.sv
// Digit-slot timer: wrapping divider, slot-end pulse,
// end-of-blank pulse and blank-phase flag.
module sevseg_slot_timer
  import sevseg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic i_clock,
  input  logic i_clear_n,
  output logic o_slot_end,
  output logic o_blank_end,
  output logic o_blank
);

  localparam int CW = clog2(SCAN_DIV);

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap      = (r_cnt == CW'(SCAN_DIV - 1));
  assign o_slot_end  = w_wrap;
  assign o_blank_end = (r_cnt == CW'(BLANK_CYCLES - 1));
  assign o_blank     = (r_cnt < CW'(BLANK_CYCLES));

  // Divider counts 0..SCAN_DIV-1; the wrap is the slot boundary
  always_ff @(posedge i_clock or negedge i_clear_n) begin
    if (!i_clear_n) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sevseg_scan_ctrl.sv
// Two-digit seven-segment scan controller with tear-free commit.
// Optional blink gating is built when SEVSEG_BLINK_EN is defined.
module sevseg_scan_ctrl
  import sevseg_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int BLINK_DIV    = 12500000
) (
  input  logic        clock,
  input  logic        clear_n,
  input  logic        out_we,
  input  logic [7:0]  out_data,
  output logic [7:0]  enc_in,
  input  logic [15:0] enc_val,
  output logic [6:0]  seg_n,
  output logic [1:0]  dig_en_n,
  output logic        busy
`ifdef SEVSEG_BLINK_EN
  ,
  input  logic        blink_req
`endif
);

  sevseg_state_t r_state;
  sevseg_state_t w_state_nxt;

  logic [7:0] r_pending;
  logic [7:0] r_active;
  logic       r_valid;
  logic       r_busy;
  logic [6:0] r_seg_n;
  logic [1:0] r_dig_en_n;

  logic       w_slot_end;
  logic       w_blank_end;
  logic       w_blank;
  logic       w_commit;
  logic       w_dark;
  logic       w_show;
  logic [6:0] w_seg_nxt;
  logic [1:0] w_dig_nxt;
  logic       w_unused_bits;

  assign w_unused_bits = ^{enc_val[15], enc_val[7]};

  sevseg_slot_timer #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .i_clock     (clock),
    .i_clear_n   (clear_n),
    .o_slot_end  (w_slot_end),
    .o_blank_end (w_blank_end),
    .o_blank     (w_blank)
  );

`ifdef SEVSEG_BLINK_EN
  localparam int BW = clog2(2 * BLINK_DIV);

  logic [BW-1:0] r_blink_cnt;

  // Free-running blink counter, period 2*BLINK_DIV
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_blink_cnt <= '0;
    end else if (r_blink_cnt == BW'(2 * BLINK_DIV - 1)) begin
      r_blink_cnt <= '0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  assign w_dark = blink_req & (r_blink_cnt >= BW'(BLINK_DIV));
`else
  localparam int unused_blink_div = BLINK_DIV;

  assign w_dark = 1'b0;
`endif

  assign w_commit = (r_state == SHOW_HI) & w_slot_end;
  assign w_show   = r_valid & ~w_dark & ~w_blank;

  // Scan state register
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state <= BLANK_LO;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next pin values
  always_comb begin
    w_state_nxt = r_state;
    w_seg_nxt   = SEG_OFF;
    w_dig_nxt   = DIG_OFF;
    unique case (r_state)
      BLANK_LO: begin
        if (w_blank_end) w_state_nxt = SHOW_LO;
      end
      SHOW_LO: begin
        if (w_slot_end) w_state_nxt = BLANK_HI;
        if (w_show) begin
          w_seg_nxt = ~enc_val[6:0];
          w_dig_nxt = 2'b10;
        end
      end
      BLANK_HI: begin
        if (w_blank_end) w_state_nxt = SHOW_HI;
      end
      SHOW_HI: begin
        if (w_slot_end) w_state_nxt = BLANK_LO;
        if (w_show) begin
          w_seg_nxt = ~enc_val[14:8];
          w_dig_nxt = 2'b01;
        end
      end
      default: begin
        w_state_nxt = BLANK_LO;
      end
    endcase
  end

  // Write capture and frame-boundary commit
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_pending <= 8'h00;
      r_active  <= 8'h00;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
    end else if (w_commit) begin
      r_busy <= 1'b0;
      if (out_we) begin
        r_pending <= out_data;
        r_active  <= out_data;
        r_valid   <= 1'b1;
      end else if (r_busy) begin
        r_active <= r_pending;
        r_valid  <= 1'b1;
      end
    end else if (out_we) begin
      r_pending <= out_data;
      r_busy    <= 1'b1;
    end
  end

  // Registered segment and digit pins
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_seg_n    <= SEG_OFF;
      r_dig_en_n <= DIG_OFF;
    end else begin
      r_seg_n    <= w_seg_nxt;
      r_dig_en_n <= w_dig_nxt;
    end
  end

  assign enc_in   = r_active;
  assign seg_n    = r_seg_n;
  assign dig_en_n = r_dig_en_n;
  assign busy     = r_busy;

endmodule
